// File: rtl/mem_access_unit.sv
// Memory stage: single-outstanding valid/ready load/store with pipeline stall; non-memory ops pass straight through.
// Optional bus watchdog (BusErr) is enabled by defining MEM_ACCESS_TIMEOUT_EN.
module mem_access_unit #(
    parameter int unsigned DATA_WIDTH = 64
`ifdef MEM_ACCESS_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 255
`endif
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [DATA_WIDTH-1:0] RdWriteDataIn,
    input  logic [4:0]            RdAddrIn,
    input  logic                  RdWriteEnableIn,
    input  logic [DATA_WIDTH-1:0] ImmIn,
    input  logic [6:0]            OpCodeIn,
    input  logic [2:0]            Funct3In,
    input  logic [DATA_WIDTH-1:0] Rs1ReadDataIn,
    input  logic [DATA_WIDTH-1:0] Rs2ReadDataIn,
    output logic                  MemReqValid,
    input  logic                  MemReqReady,
    output logic [DATA_WIDTH-1:0] MemAddr,
    output logic                  MemWriteEnable,
    output logic [DATA_WIDTH-1:0] MemWriteData,
    output logic [7:0]            MemWriteMask,
    input  logic                  MemRespValid,
    input  logic [DATA_WIDTH-1:0] MemRespData,
    output logic [DATA_WIDTH-1:0] RdWriteDataOut,
    output logic [4:0]            RdAddrOut,
    output logic                  RdWriteEnableOut,
    output logic                  StallReq,
    output logic                  MisalignErr,
    output logic                  BusErr
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   addr_q, addr_d;
    logic [2:0]              off_q, off_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [7:0]              wmask_q, wmask_d;
    logic                    store_q, store_d;
    logic [2:0]              f3_q, f3_d;
    logic [4:0]              rd_q, rd_d;
    logic                    rdwe_q, rdwe_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    timed_out;

    logic [DATA_WIDTH-1:0]   ea, st_data, ld_shift, ld_ext;
    logic [7:0]              st_mask;
    logic                    is_load, is_store, is_mem, misalign, go_mem;

    assign ea       = Rs1ReadDataIn + ImmIn;
    assign is_load  = (OpCodeIn == 7'b0000011);
    assign is_store = (OpCodeIn == 7'b0100011);
    assign is_mem   = is_load | is_store;
    assign go_mem   = is_mem & ~misalign;
    assign st_data  = Rs2ReadDataIn << {ea[2:0], 3'b000};
    assign ld_shift = MemRespData >> {off_q, 3'b000};

    always_comb begin
        misalign = 1'b0;
        st_mask  = 8'hFF;
        case (Funct3In[1:0])
            2'b00: begin misalign = 1'b0;     st_mask = 8'h01 << ea[2:0]; end
            2'b01: begin misalign = ea[0];    st_mask = 8'h03 << ea[2:0]; end
            2'b10: begin misalign = |ea[1:0]; st_mask = 8'h0F << ea[2:0]; end
            default: begin misalign = |ea[2:0]; st_mask = 8'hFF; end
        endcase
    end

    always_comb begin
        ld_ext = ld_shift;
        case (f3_q)
            3'b000:  ld_ext = {{56{ld_shift[7]}},  ld_shift[7:0]};
            3'b001:  ld_ext = {{48{ld_shift[15]}}, ld_shift[15:0]};
            3'b010:  ld_ext = {{32{ld_shift[31]}}, ld_shift[31:0]};
            3'b100:  ld_ext = {56'b0, ld_shift[7:0]};
            3'b101:  ld_ext = {48'b0, ld_shift[15:0]};
            3'b110:  ld_ext = {32'b0, ld_shift[31:0]};
            default: ld_ext = ld_shift;
        endcase
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0] cnt_q, cnt_d;
    logic       tmo_q, tmo_d;
    assign timed_out = tmo_q;
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        off_d   = off_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        store_d = store_q;
        f3_d    = f3_q;
        rd_d    = rd_q;
        rdwe_d  = rdwe_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: if (go_mem) begin
                state_d = S_REQ;
                addr_d  = {ea[DATA_WIDTH-1:3], 3'b000};
                off_d   = ea[2:0];
                store_d = is_store;
                f3_d    = Funct3In;
                rd_d    = RdAddrIn;
                rdwe_d  = RdWriteEnableIn;
                wdata_d = is_store ? st_data : '0;
                wmask_d = is_store ? st_mask : '0;
            end
            S_REQ:  if (MemReqReady) state_d = S_WAIT;
            S_WAIT: if (MemRespValid) begin
                state_d = S_DONE;
                rdata_d = store_q ? '0 : ld_ext;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef MEM_ACCESS_TIMEOUT_EN
        tmo_d = (state_q == S_IDLE) ? 1'b0 : tmo_q;
        // Watchdog only fires while the FSM is parked in REQ/WAIT; any transition restarts it.
        if ((state_q == S_REQ || state_q == S_WAIT) && state_d == state_q && cnt_q == TMO_LAST) begin
            state_d = S_DONE;
            tmo_d   = 1'b1;
        end
        if (state_d != state_q)
            cnt_d = '0;
        else if (state_q == S_REQ || state_q == S_WAIT)
            cnt_d = cnt_q + 8'd1;
        else
            cnt_d = '0;
`endif
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            off_q   <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            store_q <= 1'b0;
            f3_q    <= '0;
            rd_q    <= '0;
            rdwe_q  <= 1'b0;
            rdata_q <= '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            store_q <= store_d;
            f3_q    <= f3_d;
            rd_q    <= rd_d;
            rdwe_q  <= rdwe_d;
            rdata_q <= rdata_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign MemAddr      = addr_q;
    assign MemWriteData = wdata_q;
    assign MemWriteMask = wmask_q;

    // IDLE is a combinational bypass, so reset must also mask the pass-through path.
    always_comb begin
        MemReqValid      = 1'b0;
        MemWriteEnable   = 1'b0;
        StallReq         = 1'b0;
        MisalignErr      = 1'b0;
        BusErr           = 1'b0;
        RdWriteDataOut   = '0;
        RdAddrOut        = '0;
        RdWriteEnableOut = 1'b0;
        if (!Rst) begin
            case (state_q)
                S_IDLE: begin
                    RdWriteDataOut   = RdWriteDataIn;
                    RdAddrOut        = RdAddrIn;
                    RdWriteEnableOut = RdWriteEnableIn & ~is_mem;
                    StallReq         = go_mem;
                    MisalignErr      = is_mem & misalign;
                end
                S_REQ: begin
                    MemReqValid    = 1'b1;
                    MemWriteEnable = store_q;
                    StallReq       = 1'b1;
                    RdAddrOut      = rd_q;
                end
                S_WAIT: begin
                    StallReq  = 1'b1;
                    RdAddrOut = rd_q;
                end
                default: begin
                    RdAddrOut        = rd_q;
                    RdWriteDataOut   = store_q ? '0 : rdata_q;
                    RdWriteEnableOut = ~store_q & rdwe_q & ~timed_out;
                    BusErr           = timed_out;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: expected writebacks are queued at issue and checked when the access completes.
module tb_mem_access_unit;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ADD   = 7'b0110011;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [63:0] RdWriteDataIn, ImmIn, Rs1ReadDataIn, Rs2ReadDataIn;
    logic [4:0]  RdAddrIn;
    logic        RdWriteEnableIn;
    logic [6:0]  OpCodeIn;
    logic [2:0]  Funct3In;
    logic        MemReqValid, MemReqReady, MemWriteEnable, MemRespValid;
    logic [63:0] MemAddr, MemWriteData, MemRespData, RdWriteDataOut;
    logic [7:0]  MemWriteMask;
    logic [4:0]  RdAddrOut;
    logic        RdWriteEnableOut, StallReq, MisalignErr, BusErr;

    always #5 Clk = ~Clk;

    mem_access_unit dut (
        .Clk(Clk), .Rst(Rst),
        .RdWriteDataIn(RdWriteDataIn), .RdAddrIn(RdAddrIn), .RdWriteEnableIn(RdWriteEnableIn),
        .ImmIn(ImmIn), .OpCodeIn(OpCodeIn), .Funct3In(Funct3In),
        .Rs1ReadDataIn(Rs1ReadDataIn), .Rs2ReadDataIn(Rs2ReadDataIn),
        .MemReqValid(MemReqValid), .MemReqReady(MemReqReady), .MemAddr(MemAddr),
        .MemWriteEnable(MemWriteEnable), .MemWriteData(MemWriteData), .MemWriteMask(MemWriteMask),
        .MemRespValid(MemRespValid), .MemRespData(MemRespData),
        .RdWriteDataOut(RdWriteDataOut), .RdAddrOut(RdAddrOut), .RdWriteEnableOut(RdWriteEnableOut),
        .StallReq(StallReq), .MisalignErr(MisalignErr), .BusErr(BusErr)
    );

    typedef struct {
        string       tag;
        logic [63:0] data;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clk);
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [63:0] rs1,
                         input logic [63:0] imm, input logic [63:0] rs2, input logic [63:0] rdin,
                         input logic [4:0] rd, input logic we);
        OpCodeIn = op; Funct3In = f3; Rs1ReadDataIn = rs1; ImmIn = imm;
        Rs2ReadDataIn = rs2; RdWriteDataIn = rdin; RdAddrIn = rd; RdWriteEnableIn = we;
    endtask

    // Plays the bus side of one access from the IDLE cycle through DONE, then advances one cycle.
    task automatic do_mem(input string tag, input int ready_lat, input logic [63:0] resp,
                          input logic [63:0] e_addr, input logic e_we, input logic [63:0] e_wdata,
                          input logic [7:0] e_mask, input int e_stall, input int e_valid);
        int   stalls = 0;
        int   valids = 0;
        bit   hs = 1'b0;
        bit   done = 1'b0;
        exp_t e;
        for (int c = 0; c < 60 && !done; c++) begin
            #1;
            if (!StallReq) begin
                done = 1'b1;
                MemReqReady = 1'b0; MemRespValid = 1'b0;
                chk({tag, " done_valid"}, MemReqValid, 0);
                chk({tag, " done_buserr"}, BusErr, 0);
                if (sb.size() == 0) begin
                    chk({tag, " sb_empty"}, 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk({e.tag, " wb_we"}, RdWriteEnableOut, e.we);
                    if (e.we) begin
                        chk({e.tag, " wb_data"}, RdWriteDataOut, e.data);
                        chk({e.tag, " wb_rd"}, RdAddrOut, e.rd);
                    end
                end
            end else begin
                stalls++;
                if (MemReqValid) begin
                    valids++;
                    chk({tag, " addr"}, MemAddr, e_addr);
                    chk({tag, " wen"}, MemWriteEnable, e_we);
                    if (e_we) begin
                        chk({tag, " wdata"}, MemWriteData, e_wdata);
                        chk({tag, " wmask"}, MemWriteMask, e_mask);
                    end
                end
                MemReqReady  = MemReqValid && (valids > ready_lat);
                MemRespValid = hs;
                MemRespData  = hs ? resp : 64'h5A5A_5A5A_5A5A_5A5A;
                hs = MemReqValid && MemReqReady;
                tick();
            end
        end
        if (!done) chk({tag, " complete_timeout"}, 1, 0);
        chk({tag, " stall_cycles"}, stalls, e_stall);
        chk({tag, " valid_cycles"}, valids, e_valid);
        tick();
    endtask

    task automatic push(input string tag, input logic [63:0] data, input logic [4:0] rd, input logic we);
        exp_t e;
        e.tag = tag; e.data = data; e.rd = rd; e.we = we;
        sb.push_back(e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst = 1'b1;
        MemReqReady = 1'b0; MemRespValid = 1'b0; MemRespData = '0;
        drive(OP_ADD, 3'b000, 64'h0, 64'h0, 64'h0, 64'h99, 5'd3, 1'b1);
        tick(); tick();
        #1;
        chk("rst valid", MemReqValid, 0);
        chk("rst stall", StallReq, 0);
        chk("rst wb_we", RdWriteEnableOut, 0);
        chk("rst wb_data", RdWriteDataOut, 0);
        chk("rst addr", MemAddr, 0);
        chk("rst mask", MemWriteMask, 0);
        chk("rst buserr", BusErr, 0);
        tick();
        Rst = 1'b0;

        // ADD pass-through, zero latency
        drive(OP_ADD, 3'b000, 64'h0, 64'h0, 64'h0, 64'h1234, 5'd5, 1'b1);
        #1;
        chk("add data", RdWriteDataOut, 64'h1234);
        chk("add rd", RdAddrOut, 5);
        chk("add we", RdWriteEnableOut, 1);
        chk("add stall", StallReq, 0);
        chk("add valid", MemReqValid, 0);
        tick();

        drive(OP_LOAD, 3'b000, 64'h1000, 64'h3, 64'h0, 64'h0, 5'd7, 1'b1);
        push("lb", 64'hFFFF_FFFF_FFFF_FF80, 5'd7, 1'b1);
        do_mem("lb", 0, 64'h1122_3344_8066_7788, 64'h1000, 1'b0, 64'h0, 8'h00, 3, 1);

        drive(OP_STORE, 3'b001, 64'h2000, 64'h6, 64'hABCD, 64'h0, 5'd0, 1'b0);
        push("sh", 64'h0, 5'd0, 1'b0);
        do_mem("sh", 4, 64'h0, 64'h2000, 1'b1, 64'hABCD_0000_0000_0000, 8'hC0, 7, 5);

        drive(OP_STORE, 3'b000, 64'h10, 64'h5, 64'h1122_3344_5566_77AA, 64'h0, 5'd0, 1'b0);
        push("sb", 64'h0, 5'd0, 1'b0);
        do_mem("sb", 0, 64'h0, 64'h10, 1'b1, 64'h6677_AA00_0000_0000, 8'h20, 3, 1);

        drive(OP_STORE, 3'b011, 64'h4000, 64'h8, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 5'd0, 1'b0);
        push("sd", 64'h0, 5'd0, 1'b0);
        do_mem("sd", 1, 64'h0, 64'h4008, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 4, 2);

        drive(OP_LOAD, 3'b101, 64'h3000, 64'h2, 64'h0, 64'h0, 5'd9, 1'b1);
        push("lhu", 64'h0000_0000_0000_8765, 5'd9, 1'b1);
        do_mem("lhu", 0, 64'hFFFF_FFFF_8765_FFFF, 64'h3000, 1'b0, 64'h0, 8'h00, 3, 1);

        drive(OP_LOAD, 3'b010, 64'h3004, 64'h0, 64'h0, 64'h0, 5'd10, 1'b1);
        push("lw", 64'hFFFF_FFFF_9ABC_DEF0, 5'd10, 1'b1);
        do_mem("lw", 2, 64'h9ABC_DEF0_1111_2222, 64'h3000, 1'b0, 64'h0, 8'h00, 5, 3);

        drive(OP_LOAD, 3'b100, 64'h5000, 64'h7, 64'h0, 64'h0, 5'd12, 1'b1);
        push("lbu", 64'h0000_0000_0000_00F1, 5'd12, 1'b1);
        do_mem("lbu", 0, 64'hF122_3344_5566_7788, 64'h5000, 1'b0, 64'h0, 8'h00, 3, 1);

        // Misaligned accesses: error pulse, no stall, no request
        drive(OP_LOAD, 3'b010, 64'h1000, 64'h2, 64'h0, 64'h77, 5'd3, 1'b1);
        #1;
        chk("lw_mis err", MisalignErr, 1);
        chk("lw_mis valid", MemReqValid, 0);
        chk("lw_mis stall", StallReq, 0);
        chk("lw_mis we", RdWriteEnableOut, 0);
        tick();
        drive(OP_STORE, 3'b011, 64'h6000, 64'h4, 64'h1, 64'h0, 5'd0, 1'b0);
        #1;
        chk("lw_mis next_valid", MemReqValid, 0);
        chk("sd_mis err", MisalignErr, 1);
        chk("sd_mis stall", StallReq, 0);
        tick();
        drive(OP_ADD, 3'b000, 64'h0, 64'h0, 64'h0, 64'h42, 5'd8, 1'b1);
        #1;
        chk("sd_mis next_valid", MemReqValid, 0);
        chk("post_mis err", MisalignErr, 0);
        chk("post_mis data", RdWriteDataOut, 64'h42);
        tick();

        // LD with address wrap, then reset while waiting for the response
        drive(OP_LOAD, 3'b011, 64'hFFFF_FFFF_FFFF_FFF8, 64'h10, 64'h0, 64'h0, 5'd4, 1'b1);
        #1;
        chk("ld_wrap idle_stall", StallReq, 1);
        MemReqReady = 1'b1;
        tick(); #1;
        chk("ld_wrap valid", MemReqValid, 1);
        chk("ld_wrap addr", MemAddr, 64'h8);
        tick(); #1;
        MemReqReady = 1'b0;
        chk("ld_wrap wait_valid", MemReqValid, 0);
        chk("ld_wrap wait_stall", StallReq, 1);
        Rst = 1'b1;
        MemRespValid = 1'b1; MemRespData = 64'hCCCC_CCCC_CCCC_CCCC;
        tick(); #1;
        chk("rst_wait valid", MemReqValid, 0);
        chk("rst_wait stall", StallReq, 0);
        chk("rst_wait addr", MemAddr, 0);
        chk("rst_wait wdata", MemWriteData, 0);
        chk("rst_wait wb_data", RdWriteDataOut, 0);
        chk("rst_wait wb_rd", RdAddrOut, 0);
        chk("rst_wait wb_we", RdWriteEnableOut, 0);
        drive(OP_ADD, 3'b000, 64'h0, 64'h0, 64'h0, 64'h55, 5'd6, 1'b1);
        Rst = 1'b0;
        tick(); #1;
        MemRespValid = 1'b0;
        chk("post_rst data", RdWriteDataOut, 64'h55);
        chk("post_rst we", RdWriteEnableOut, 1);
        chk("post_rst stall", StallReq, 0);
        chk("post_rst valid", MemReqValid, 0);
        tick();

`ifdef MEM_ACCESS_TIMEOUT_EN
        begin
            int stalls = 0;
            bit dropped = 1'b0;
            drive(OP_LOAD, 3'b011, 64'h7000, 64'h0, 64'h0, 64'h0, 5'd13, 1'b1);
            MemReqReady = 1'b1;
            for (int c = 0; c < 600 && !dropped; c++) begin
                #1;
                if (!StallReq) begin
                    dropped = 1'b1;
                    chk("tmo buserr", BusErr, 1);
                    chk("tmo we", RdWriteEnableOut, 0);
                end else begin
                    stalls++;
                    tick();
                end
            end
            MemReqReady = 1'b0;
            if (!dropped) chk("tmo bound", 1, 0);
            chk("tmo stall_cycles", stalls, 257);
            tick();
            drive(OP_ADD, 3'b000, 64'h0, 64'h0, 64'h0, 64'h1, 5'd1, 1'b1);
            #1;
            chk("tmo pulse_end", BusErr, 0);
            tick();
        end
`endif

        chk("sb drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
